tag_pool: RTL and testbench

TAG_POOL -- requirements
Module: tag_pool

---
 rtl/tag_pool_pkg.sv | 15 +
 rtl/tag_pool_if.sv | 31 +++
 rtl/tag_pool_fifo.sv | 65 ++++++
 rtl/tag_pool.sv | 123 ++++++++++++
 tb/tb_tag_pool.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tag_pool_pkg.sv
// Shared types for the tag pool: FSM state encoding and the count-width helper.
package tag_pool_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Width needed to hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tag_pool_if.sv
// Tag pool client bus: allocation (tag_out*), release (tag_in*) and status.
interface tag_pool_if
   import tag_pool_pkg::*;
#(
   parameter int TAG_WIDTH = 8,
   parameter int NUM_TAGS  = 64
) ();

   localparam int CW = cnt_width(NUM_TAGS);

   logic [TAG_WIDTH-1:0] tag_out;
   logic                 tag_out_valid;
   logic                 tag_out_rdy;
   logic [TAG_WIDTH-1:0] tag_in;
   logic                 tag_in_valid;
   logic                 tag_almost_empty;
   logic [CW-1:0]        free_count;
   logic                 tag_init_done;
   logic                 tag_err;

   modport slave (
      output tag_out, tag_out_valid, tag_almost_empty, free_count, tag_init_done, tag_err,
      input  tag_out_rdy, tag_in, tag_in_valid
   );

   modport master (
      input  tag_out, tag_out_valid, tag_almost_empty, free_count, tag_init_done, tag_err,
      output tag_out_rdy, tag_in, tag_in_valid
   );

endinterface

// File: rtl/tag_pool_fifo.sv
// Synchronous first-word-fall-through register FIFO holding the free list.
module tag_pool_fifo
   import tag_pool_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push_i,
   input  logic [WIDTH-1:0]              din_i,
   input  logic                          pop_i,
   output logic [WIDTH-1:0]              dout_o,
   output logic                          empty_o,
   output logic [cnt_width(DEPTH)-1:0]   count_o
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Explicit wrap so non-power-of-2 depths stay in range.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_push = push_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/tag_pool.sv
// Tag allocator: loads tags 0..NUM_TAGS-1 after reset, then hands them out and takes them back.
// Optional double-free detection via macro TAG_POOL_DOUBLE_FREE_CHECK_EN.
module tag_pool
   import tag_pool_pkg::*;
#(
   parameter int TAG_WIDTH           = 8,
   parameter int NUM_TAGS            = 64,
   parameter int ALMOST_EMPTY_THRESH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   tag_pool_if.slave  bus
);

   localparam int CW = cnt_width(NUM_TAGS);

   state_e               state_q, state_d;
   logic                 rst_sync_q;
   logic [TAG_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic                 tag_err_q, tag_err_d;
   logic                 fifo_push, fifo_pop, fifo_empty;
   logic [TAG_WIDTH-1:0] fifo_din, fifo_dout;
   logic [CW-1:0]        fifo_count;
   logic                 out_valid;
   logic                 rel_bad, rel_ok;

`ifdef TAG_POOL_DOUBLE_FREE_CHECK_EN
   logic [NUM_TAGS-1:0]  outst_q, outst_d;
   logic                 rel_owned;

   always_comb begin
      rel_owned = 1'b0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (bus.tag_in == TAG_WIDTH'(i)) rel_owned = outst_q[i];
      end
   end

   always_comb begin
      outst_d = outst_q;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
         if (rel_ok && bus.tag_in == TAG_WIDTH'(i))    outst_d[i] = 1'b0;
         if (fifo_pop && fifo_dout == TAG_WIDTH'(i))   outst_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) outst_q <= '0;
      else        outst_q <= outst_d;
   end
`endif

   always_comb begin
      rel_bad = (state_q != RUN) || (int'(bus.tag_in) >= NUM_TAGS) ||
                (fifo_count == CW'(NUM_TAGS));
`ifdef TAG_POOL_DOUBLE_FREE_CHECK_EN
      if (!rel_owned) rel_bad = 1'b1;
`endif
   end

   assign rel_ok    = bus.tag_in_valid && !rel_bad;
   assign tag_err_d = bus.tag_in_valid && rel_bad;

   // rst_sync_q is the first synchroniser stage; state_q leaving IDLE acts as the second.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      fifo_push  = 1'b0;
      fifo_din   = bus.tag_in;
      unique case (state_q)
         IDLE: if (rst_sync_q) state_d = INIT;
         INIT: begin
            fifo_push  = 1'b1;
            fifo_din   = init_cnt_q;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == TAG_WIDTH'(NUM_TAGS - 1)) begin
               state_d    = RUN;
               init_cnt_d = '0;
            end
         end
         RUN:     fifo_push = rel_ok;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 1'b0;
         state_q    <= IDLE;
         init_cnt_q <= '0;
         tag_err_q  <= 1'b0;
      end else begin
         rst_sync_q <= 1'b1;
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         tag_err_q  <= tag_err_d;
      end
   end

   assign out_valid = (state_q == RUN) && !fifo_empty;
   assign fifo_pop  = out_valid && bus.tag_out_rdy;

   tag_pool_fifo #(
      .WIDTH (TAG_WIDTH),
      .DEPTH (NUM_TAGS)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .din_i   (fifo_din),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign bus.tag_out          = out_valid ? fifo_dout : '0;
   assign bus.tag_out_valid    = out_valid;
   assign bus.free_count       = fifo_count;
   assign bus.tag_almost_empty = (int'(fifo_count) <= ALMOST_EMPTY_THRESH);
   assign bus.tag_init_done    = (state_q == RUN);
   assign bus.tag_err          = tag_err_q;

endmodule

// File: tb/tb_tag_pool.sv
// Directed bench for tag_pool (64 x 8-bit instance) plus a 48 x 6-bit instance for wrap checks.
module tb_tag_pool;
   import tag_pool_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   tag_pool_if #(.TAG_WIDTH(8), .NUM_TAGS(64)) bus ();
   tag_pool_if #(.TAG_WIDTH(6), .NUM_TAGS(48)) bus48 ();

   tag_pool #(.TAG_WIDTH(8), .NUM_TAGS(64), .ALMOST_EMPTY_THRESH(8)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus)
   );

   tag_pool #(.TAG_WIDTH(6), .NUM_TAGS(48), .ALMOST_EMPTY_THRESH(8)) dut48 (
      .clk (clk), .rst_n (rst_n), .bus (bus48)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.tag_out_rdy = 1'b0;   bus.tag_in = '0;   bus.tag_in_valid = 1'b0;
      bus48.tag_out_rdy = 1'b0; bus48.tag_in = '0; bus48.tag_in_valid = 1'b0;
      repeat (3) tick();
      vectors++;
      if ({bus.tag_out_valid, bus.tag_init_done, bus.tag_err, bus.tag_almost_empty,
           bus.free_count, bus.tag_out} !== {1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 8'd0}) begin
         miscompares++;
         $display("FAIL reset_main: got %h want %h", {bus.tag_out_valid, bus.tag_init_done,
                  bus.tag_err, bus.tag_almost_empty, bus.free_count, bus.tag_out},
                  {1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 8'd0});
      end
      vectors++;
      if ({bus48.tag_out_valid, bus48.tag_init_done, bus48.tag_err, bus48.tag_almost_empty,
           bus48.free_count, bus48.tag_out} !== {1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0}) begin
         miscompares++;
         $display("FAIL reset_48: got %h want %h", {bus48.tag_out_valid, bus48.tag_init_done,
                  bus48.tag_err, bus48.tag_almost_empty, bus48.free_count, bus48.tag_out},
                  {1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0});
      end
   endtask

   // Edge 1 is the first post-reset edge; init must complete at edge 66 (65 cycles later).
   task automatic test_init();
      rst_n = 1'b1;
      tick();
      for (int e = 2; e <= 66; e++) begin
         if (e == 11) begin
            bus.tag_in = 8'd3;
            bus.tag_in_valid = 1'b1;
         end
         tick();
         bus.tag_in_valid = 1'b0;
         if (e == 11) begin
            vectors++;
            if ({bus.tag_err, bus.tag_init_done, bus.free_count} !== {1'b1, 1'b0, 7'd9}) begin
               miscompares++;
               $display("FAIL init_release_err: got %h want %h",
                        {bus.tag_err, bus.tag_init_done, bus.free_count}, {1'b1, 1'b0, 7'd9});
            end
         end
         if (e == 12) begin
            vectors++;
            if (bus.tag_err !== 1'b0) begin
               miscompares++;
               $display("FAIL init_err_pulse: got %b want 0", bus.tag_err);
            end
         end
         if (e == 65) begin
            vectors++;
            if ({bus.tag_init_done, bus.tag_out_valid, bus.free_count} !== {1'b0, 1'b0, 7'd63}) begin
               miscompares++;
               $display("FAIL init_not_yet: got %h want %h",
                        {bus.tag_init_done, bus.tag_out_valid, bus.free_count}, {1'b0, 1'b0, 7'd63});
            end
         end
      end
      vectors++;
      if ({bus.tag_out_valid, bus.tag_init_done, bus.tag_err, bus.tag_almost_empty,
           bus.free_count, bus.tag_out} !== {1'b1, 1'b1, 1'b0, 1'b0, 7'd64, 8'd0}) begin
         miscompares++;
         $display("FAIL init_done: got %h want %h", {bus.tag_out_valid, bus.tag_init_done,
                  bus.tag_err, bus.tag_almost_empty, bus.free_count, bus.tag_out},
                  {1'b1, 1'b1, 1'b0, 1'b0, 7'd64, 8'd0});
      end
      vectors++;
      if ({bus48.tag_init_done, bus48.free_count, bus48.tag_out} !== {1'b1, 6'd48, 6'd0}) begin
         miscompares++;
         $display("FAIL init_done_48: got %h want %h",
                  {bus48.tag_init_done, bus48.free_count, bus48.tag_out}, {1'b1, 6'd48, 6'd0});
      end
   endtask

   task automatic test_full_release();
      bus.tag_in = 8'd3;
      bus.tag_in_valid = 1'b1;
      tick();
      bus.tag_in_valid = 1'b0;
      vectors++;
      if ({bus.tag_err, bus.free_count} !== {1'b1, 7'd64}) begin
         miscompares++;
         $display("FAIL full_release: got %h want %h", {bus.tag_err, bus.free_count}, {1'b1, 7'd64});
      end
      tick();
      vectors++;
      if (bus.tag_err !== 1'b0) begin
         miscompares++;
         $display("FAIL full_err_pulse: got %b want 0", bus.tag_err);
      end
   endtask

   task automatic test_pop_all();
      bus.tag_out_rdy = 1'b1;
      for (int i = 0; i < 64; i++) begin
         vectors++;
         if ({bus.tag_out_valid, bus.tag_almost_empty, bus.free_count, bus.tag_out} !==
             {1'b1, ((64 - i) <= 8), 7'(64 - i), 8'(i)}) begin
            miscompares++;
            $display("FAIL pop_all[%0d]: got %h want %h", i,
                     {bus.tag_out_valid, bus.tag_almost_empty, bus.free_count, bus.tag_out},
                     {1'b1, ((64 - i) <= 8), 7'(64 - i), 8'(i)});
         end
         tick();
      end
      bus.tag_out_rdy = 1'b0;
      vectors++;
      if ({bus.tag_out_valid, bus.tag_almost_empty, bus.free_count} !== {1'b0, 1'b1, 7'd0}) begin
         miscompares++;
         $display("FAIL pop_all_empty: got %h want %h",
                  {bus.tag_out_valid, bus.tag_almost_empty, bus.free_count}, {1'b0, 1'b1, 7'd0});
      end
   endtask

   task automatic test_empty_release();
      bus.tag_in = 8'h2A;
      bus.tag_in_valid = 1'b1;
      tick();
      bus.tag_in_valid = 1'b0;
      vectors++;
      if ({bus.tag_out_valid, bus.tag_err, bus.free_count, bus.tag_out} !== {1'b1, 1'b0, 7'd1, 8'h2A}) begin
         miscompares++;
         $display("FAIL empty_release: got %h want %h",
                  {bus.tag_out_valid, bus.tag_err, bus.free_count, bus.tag_out}, {1'b1, 1'b0, 7'd1, 8'h2A});
      end
      bus.tag_out_rdy = 1'b1;
      bus.tag_in = 8'h11;
      bus.tag_in_valid = 1'b1;
      tick();
      bus.tag_out_rdy = 1'b0;
      bus.tag_in_valid = 1'b0;
      vectors++;
      if ({bus.tag_out_valid, bus.tag_err, bus.free_count, bus.tag_out} !== {1'b1, 1'b0, 7'd1, 8'h11}) begin
         miscompares++;
         $display("FAIL pop_and_release: got %h want %h",
                  {bus.tag_out_valid, bus.tag_err, bus.free_count, bus.tag_out}, {1'b1, 1'b0, 7'd1, 8'h11});
      end
   endtask

   task automatic test_bad_tag();
      bus.tag_in = 8'd70;
      bus.tag_in_valid = 1'b1;
      tick();
      bus.tag_in_valid = 1'b0;
      vectors++;
      if ({bus.tag_err, bus.free_count, bus.tag_out} !== {1'b1, 7'd1, 8'h11}) begin
         miscompares++;
         $display("FAIL bad_tag: got %h want %h", {bus.tag_err, bus.free_count, bus.tag_out},
                  {1'b1, 7'd1, 8'h11});
      end
      tick();
      vectors++;
      if (bus.tag_err !== 1'b0) begin
         miscompares++;
         $display("FAIL bad_tag_pulse: got %b want 0", bus.tag_err);
      end
   endtask

   task automatic test_double_free();
      logic [7:0] rel_tag [3];
      logic [7:0] exp_err [3];
      logic [7:0] exp_cnt [3];
      rel_tag[0] = 8'd5;  rel_tag[1] = 8'd5;  rel_tag[2] = 8'h11;
`ifdef TAG_POOL_DOUBLE_FREE_CHECK_EN
      exp_err[0] = 8'd0;  exp_err[1] = 8'd1;  exp_err[2] = 8'd1;
      exp_cnt[0] = 8'd2;  exp_cnt[1] = 8'd2;  exp_cnt[2] = 8'd2;
`else
      exp_err[0] = 8'd0;  exp_err[1] = 8'd0;  exp_err[2] = 8'd0;
      exp_cnt[0] = 8'd2;  exp_cnt[1] = 8'd3;  exp_cnt[2] = 8'd4;
`endif
      for (int i = 0; i < 3; i++) begin
         bus.tag_in = rel_tag[i];
         bus.tag_in_valid = 1'b1;
         tick();
         vectors++;
         if ({bus.tag_err, bus.free_count} !== {exp_err[i][0], exp_cnt[i][6:0]}) begin
            miscompares++;
            $display("FAIL double_free[%0d]: got %h want %h", i, {bus.tag_err, bus.free_count},
                     {exp_err[i][0], exp_cnt[i][6:0]});
         end
      end
      bus.tag_in_valid = 1'b0;
      tick();
   endtask

   task automatic test_midreset();
      bus.tag_out_rdy = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if ({bus.tag_out_valid, bus.tag_init_done, bus.tag_err, bus.tag_almost_empty,
              bus.free_count, bus.tag_out} !== {1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL midreset[%0d]: got %h want %h", k, {bus.tag_out_valid, bus.tag_init_done,
                     bus.tag_err, bus.tag_almost_empty, bus.free_count, bus.tag_out},
                     {1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 8'd0});
         end
         if (k == 0) repeat (3) tick();
      end
      bus.tag_out_rdy = 1'b0;
      rst_n = 1'b1;
      tick();
      repeat (65) tick();
      vectors++;
      if ({bus.tag_init_done, bus.free_count, bus48.tag_init_done, bus48.free_count} !==
          {1'b1, 7'd64, 1'b1, 6'd48}) begin
         miscompares++;
         $display("FAIL reinit: got %h want %h",
                  {bus.tag_init_done, bus.free_count, bus48.tag_init_done, bus48.free_count},
                  {1'b1, 7'd64, 1'b1, 6'd48});
      end
      bus.tag_out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({bus.tag_out_valid, bus.tag_out} !== {1'b1, 8'(i)}) begin
            miscompares++;
            $display("FAIL restart_tag[%0d]: got %h want %h", i, {bus.tag_out_valid, bus.tag_out},
                     {1'b1, 8'(i)});
         end
         tick();
      end
      bus.tag_out_rdy = 1'b0;
   endtask

   task automatic test_random48();
      logic [5:0] free_q[$];
      logic [5:0] out_q[$];
      logic [5:0] tg;
      bit         rdy, rel;
      int         idx;
      for (int i = 0; i < 48; i++) free_q.push_back(6'(i));
      for (int c = 0; c < 200; c++) begin
         vectors++;
         if ({bus48.tag_out_valid, bus48.tag_err, bus48.free_count} !==
             {(free_q.size() != 0), 1'b0, 6'(free_q.size())}) begin
            miscompares++;
            $display("FAIL rand48_status[%0d]: got %h want %h", c,
                     {bus48.tag_out_valid, bus48.tag_err, bus48.free_count},
                     {(free_q.size() != 0), 1'b0, 6'(free_q.size())});
         end
         if (free_q.size() != 0) begin
            vectors++;
            if (bus48.tag_out !== free_q[0]) begin
               miscompares++;
               $display("FAIL rand48_tag[%0d]: got %0d want %0d", c, bus48.tag_out, free_q[0]);
            end
         end
         rdy = ($urandom_range(0, 3) != 0);
         rel = (out_q.size() != 0) && ($urandom_range(0, 1) == 1);
         tg  = '0;
         if (rel) begin
            idx = int'($urandom_range(0, out_q.size() - 1));
            tg  = out_q[idx];
            out_q.delete(idx);
         end
         bus48.tag_out_rdy  = rdy;
         bus48.tag_in       = tg;
         bus48.tag_in_valid = rel;
         if (rdy && free_q.size() != 0) out_q.push_back(free_q.pop_front());
         if (rel) free_q.push_back(tg);
         tick();
      end
      bus48.tag_out_rdy  = 1'b0;
      bus48.tag_in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_init();
      test_full_release();
      test_pop_all();
      test_empty_release();
      test_bad_tag();
      test_double_free();
      test_midreset();
      test_random48();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
